// File: rtl/divisor_seq_5x4bits.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one trial subtraction per cycle.
// Optional macro DIVSEQ_DIV_ZERO_CHECK_EN enables the zero-divisor shortcut and the div_zero flag.
module divisor_seq_5x4bits #(
    parameter int DW = 5,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          div_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [DW-1:0] dvd_r, quo_r, q_r;
    logic [VW-1:0] dvs_r, r_r;
    logic [VW:0]   rem_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r, done_r;

    logic [VW:0]   sh_s, rem_nxt_s;
    logic [VW+1:0] diff_s;
    logic          borrow_s, last_s, zero_short_s;
    logic [DW-1:0] quo_nxt_s;

`ifdef DIVSEQ_DIV_ZERO_CHECK_EN
    assign zero_short_s = (b == {VW{1'b0}});
`else
    assign zero_short_s = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor
    always_comb begin
        sh_s      = {rem_r[VW-1:0], dvd_r[DW-1]};
        diff_s    = {1'b0, sh_s} - {2'b00, dvs_r};
        borrow_s  = diff_s[VW+1];
        rem_nxt_s = borrow_s ? sh_s : diff_s[VW:0];
        quo_nxt_s = {quo_r[DW-2:0], ~borrow_s};
        last_s    = (cnt_r == {CW{1'b0}});
    end

    // Next-state logic; the zero-divisor shortcut is taken only from IDLE so done never repeats
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = zero_short_s ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r  <= {DW{1'b0}};
            dvs_r  <= {VW{1'b0}};
            rem_r  <= {(VW+1){1'b0}};
            quo_r  <= {DW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            q_r    <= {DW{1'b0}};
            r_r    <= {VW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dvd_r <= a;
                        dvs_r <= b;
                        rem_r <= {(VW+1){1'b0}};
                        quo_r <= {DW{1'b0}};
                        cnt_r <= CNT_LOAD;
                        if (zero_short_s && (state_r == ST_IDLE)) begin
                            q_r <= {DW{1'b1}};
                            r_r <= a[VW-1:0];
                        end
                    end
                end
                ST_RUN: begin
                    dvd_r <= {dvd_r[DW-2:0], 1'b0};
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (last_s) begin
                        q_r <= quo_nxt_s;
                        r_r <= rem_nxt_s[VW-1:0];
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

`ifdef DIVSEQ_DIV_ZERO_CHECK_EN
    logic div_zero_r;

    // Zero-divisor flag, updated on every completion (shortcut or full run)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_zero_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start && zero_short_s) begin
            div_zero_r <= 1'b1;
        end else if ((state_r == ST_RUN) && last_s) begin
            div_zero_r <= (dvs_r == {VW{1'b0}});
        end
    end

    assign div_zero = div_zero_r;
`else
    assign div_zero = 1'b0;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign q    = q_r;
    assign r    = r_r;

endmodule

// File: tb/tb_divisor_seq_5x4bits.sv
// Directed self-checking bench for divisor_seq_5x4bits (honours DIVSEQ_DIV_ZERO_CHECK_EN when defined).
module tb_divisor_seq_5x4bits;

    localparam int DW = 5;
    localparam int VW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          div_zero;

    int vectors    = 0;
    int miscompares = 0;

    divisor_seq_5x4bits #(.DW(DW), .VW(VW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start from IDLE, wait for done (bounded), check latency, busy span and result
    task automatic run_op(input string tag, input logic [DW-1:0] av, input logic [VW-1:0] bv,
                          input int exp_q, input int exp_r, input int exp_dz, input int exp_lat);
        int lat;
        int busy_cnt;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        chk({tag, "_q"}, q, exp_q);
        chk({tag, "_r"}, r, exp_r);
        chk({tag, "_dz"}, div_zero, exp_dz);
        tick();
        chk({tag, "_done_single"}, done, 0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dz", div_zero, 0);
        rst_n = 1'b1;
        tick();

        run_op("d23_4", 5'd23, 4'd4, 5, 3, 0, 6);
        run_op("d31_1", 5'd31, 4'd1, 31, 0, 0, 6);
        run_op("d3_7", 5'd3, 4'd7, 0, 3, 0, 6);
        run_op("d0_15", 5'd0, 4'd15, 0, 0, 0, 6);
        run_op("d31_15", 5'd31, 4'd15, 2, 1, 0, 6);
`ifdef DIVSEQ_DIV_ZERO_CHECK_EN
        run_op("d19_0", 5'd19, 4'd0, 31, 3, 1, 1);
        run_op("d14_3_after_dz", 5'd14, 4'd3, 4, 2, 0, 6);
`else
        run_op("d19_0", 5'd19, 4'd0, 31, 3, 0, 6);
`endif

        // start re-pulsed at cycle 3 must be ignored
        a = 5'd23; b = 4'd4; start = 1'b1;
        tick();                              // cycle 1
        start = 1'b0;
        tick();                              // cycle 2
        tick();                              // cycle 3
        a = 5'd9; b = 4'd2; start = 1'b1;
        tick();                              // cycle 4
        start = 1'b0;
        chk("ign_busy_c4", busy, 1);
        tick();                              // cycle 5
        tick();                              // cycle 6
        chk("ign_done", done, 1);
        chk("ign_q", q, 5);
        chk("ign_r", r, 3);
        tick();
        chk("ign_idle_done", done, 0);
        chk("ign_idle_busy", busy, 0);

        // start held through DONE: back-to-back operations
        a = 5'd23; b = 4'd4; start = 1'b1;
        tick();                              // cycle 1
        a = 5'd9; b = 4'd2;
        for (int i = 0; i < 5; i++) tick();  // cycle 6
        chk("b2b_done1", done, 1);
        chk("b2b_q1", q, 5);
        chk("b2b_r1", r, 3);
        tick();                              // cycle 7
        start = 1'b0;
        chk("b2b_busy7", busy, 1);
        chk("b2b_nodone7", done, 0);
        for (int i = 0; i < 4; i++) tick();  // cycle 11
        chk("b2b_nodone11", done, 0);
        chk("b2b_q_held", q, 5);
        tick();                              // cycle 12
        chk("b2b_done2", done, 1);
        chk("b2b_q2", q, 4);
        chk("b2b_r2", r, 1);
        tick();

        // reset asserted mid-run aborts immediately with no later done
        a = 5'd23; b = 4'd4; start = 1'b1;
        tick();                              // cycle 1
        start = 1'b0;
        tick();                              // cycle 2
        tick();                              // cycle 3
        chk("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        run_op("post_abort_9_2", 5'd9, 4'd2, 4, 1, 0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
